// File: rtl/q_capture_fifo.sv
// q_capture_fifo
// Captures the word from a bank of Q-flops on each edge where every flop
// acknowledges. The word goes into a first-word-fall-through FIFO that a
// valid/ready consumer drains. The aggregated acknowledge is withheld when
// there is no room, so the Q-clock stalls instead of losing data. A sticky
// flag reports flops that stay in a partial-acknowledge state for too long.
module q_capture_fifo #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         q_data,
    input  logic [WIDTH-1:0]         q_ack,
    output logic                     ack_out,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     settle_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0] TIMEOUT_C = SW'(TIMEOUT);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [SW-1:0]    stall_cnt;
    logic             all_ack;
    logic             partial_ack;
    logic             push;
    logic             pop;

    // Handshake decode. The flops never see the reset term of ack_out because
    // they are held in reset while rst is low anyway; only the output needs it.
    always_comb begin
        all_ack     = &q_ack;
        partial_ack = (|q_ack) & ~all_ack;
        push        = all_ack & (~full | out_ready);
        pop         = out_valid & out_ready;
        ack_out     = push & rst;
        out_valid   = (count != '0);
        full        = (count == DEPTH_C);
        out_data    = mem[rd_ptr];
    end

    // Storage: cleared on reset so out_data reads 0, written at the tail on push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= q_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Settle monitor: count consecutive partial-ack cycles, saturating, and
    // latch the error on the edge that completes the TIMEOUT-th such cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            settle_err <= 1'b0;
        end else begin
            if (partial_ack) begin
                if (stall_cnt != TIMEOUT_C) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
                if (stall_cnt >= TIMEOUT_C - 1'b1) begin
                    settle_err <= 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_q_capture_fifo.sv
// Testbench for q_capture_fifo: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the capture FIFO.
module tb_q_capture_fifo;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] q_data;
    logic [WIDTH-1:0] q_ack;
    logic             ack_out;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       count;
    logic             full;
    logic             settle_err;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    int               m_stall;
    bit               m_err;

    logic [13:0] obs;
    assign obs = {out_valid, (out_valid ? out_data : 8'h00), count, full, settle_err};

    q_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .q_data(q_data), .q_ack(q_ack), .ack_out(ack_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .settle_err(settle_err)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] expected_vec();
        logic       v;
        logic [7:0] d;
        v = (mq.size() != 0);
        d = v ? mq[0] : 8'h00;
        return {v, d, 3'(mq.size()), (mq.size() == DEPTH), m_err};
    endfunction

    function automatic bit model_push();
        return rst && (q_ack == 8'hFF) && ((mq.size() < DEPTH) || out_ready);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_stall = 0;
        m_err   = 1'b0;
    endtask

    // One clock edge; the model consumes the inputs as they stood before the edge.
    task automatic tick();
        bit         p;
        bit         po;
        bit         partial;
        logic [7:0] d;
        p       = model_push();
        po      = (mq.size() != 0) && out_ready;
        partial = (q_ack != 8'h00) && (q_ack != 8'hFF);
        d       = q_data;
        @(posedge clk);
        if (rst) begin
            if (po) void'(mq.pop_front());
            if (p) mq.push_back(d);
            if (partial) m_stall = (m_stall < TIMEOUT) ? m_stall + 1 : TIMEOUT;
            else m_stall = 0;
            if (m_stall == TIMEOUT) m_err = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; q_ack = '0; q_data = '0; out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; q_ack = 8'hFF; q_data = 8'h5A; out_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checks_total++;
        if ({ack_out, out_data, out_valid, count, full, settle_err} !== 15'h0) begin
            $display("[TB] FAIL reset_values: got ack=%b data=%h valid=%b count=%0d full=%b err=%b, want all 0",
                     ack_out, out_data, out_valid, count, full, settle_err);
        end else checks_passed++;
        rst = 1'b1; q_ack = 8'hFF; q_data = 8'hA5; out_ready = 1'b0;
        tick();
        q_ack = 8'h00;
        checks_total++;
        if ({out_valid, out_data, count} !== {1'b1, 8'hA5, 3'd1}) begin
            $display("[TB] FAIL single_word: got valid=%b data=%h count=%0d, want 1 a5 1",
                     out_valid, out_data, count);
        end else checks_passed++;
    endtask

    task automatic test_fill_stall();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            q_ack = 8'hFF; q_data = 8'(i);
            tick();
        end
        #1;
        checks_total++;
        if ({full, count, ack_out} !== {1'b1, 3'd4, 1'b0}) begin
            $display("[TB] FAIL fill_full: got full=%b count=%0d ack=%b, want 1 4 0", full, count, ack_out);
        end else checks_passed++;
        for (int i = 0; i < 20; i++) tick();
        checks_total++;
        if ({settle_err, count, ack_out} !== {1'b0, 3'd4, 1'b0}) begin
            $display("[TB] FAIL stall_no_err: got err=%b count=%0d ack=%b, want 0 4 0", settle_err, count, ack_out);
        end else checks_passed++;
        q_ack = 8'h00; out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks_total++;
            if ({out_valid, out_data} !== {1'b1, 8'(i)}) begin
                $display("[TB] FAIL drain_order: got valid=%b data=%h, want 1 %h", out_valid, out_data, 8'(i));
            end else checks_passed++;
            tick();
        end
        checks_total++;
        if (out_valid !== 1'b0) begin
            $display("[TB] FAIL drain_empty: got valid=%b, want 0", out_valid);
        end else checks_passed++;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] want[4] = '{8'h11, 8'h12, 8'h13, 8'h20};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q_ack = 8'hFF; q_data = 8'(8'h10 + i);
            tick();
        end
        out_ready = 1'b1; q_ack = 8'hFF; q_data = 8'h20;
        #1;
        checks_total++;
        if (ack_out !== 1'b1) begin
            $display("[TB] FAIL full_pushpop_ack: got ack=%b, want 1", ack_out);
        end else checks_passed++;
        tick();
        q_ack = 8'h00;
        checks_total++;
        if ({count, out_data} !== {3'd4, 8'h11}) begin
            $display("[TB] FAIL full_pushpop_state: got count=%0d head=%h, want 4 11", count, out_data);
        end else checks_passed++;
        for (int i = 0; i < 4; i++) begin
            checks_total++;
            if ({out_valid, out_data} !== {1'b1, want[i]}) begin
                $display("[TB] FAIL full_pushpop_drain: got valid=%b data=%h, want 1 %h", out_valid, out_data, want[i]);
            end else checks_passed++;
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [7:0] got[$];
        int         max_count = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            q_ack  = (i < 12) ? 8'hFF : 8'h00;
            q_data = 8'(i);
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
            if (int'(count) > max_count) max_count = int'(count);
        end
        checks_total++;
        if (max_count > 1 || got.size() != 12) begin
            $display("[TB] FAIL wrap_count: got max_count=%0d received=%0d, want <=1 and 12", max_count, got.size());
        end else checks_passed++;
        for (int i = 0; i < got.size(); i++) begin
            checks_total++;
            if (got[i] !== 8'(i)) begin
                $display("[TB] FAIL wrap_order: got word%0d=%h, want %h", i, got[i], 8'(i));
            end else checks_passed++;
        end
    endtask

    task automatic test_settle();
        do_reset();
        q_ack = 8'h0F; q_data = 8'h33;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        checks_total++;
        if ({settle_err, count, ack_out} !== {1'b0, 3'd0, 1'b0}) begin
            $display("[TB] FAIL settle_before: got err=%b count=%0d ack=%b, want 0 0 0", settle_err, count, ack_out);
        end else checks_passed++;
        tick();
        checks_total++;
        if (settle_err !== 1'b1) begin
            $display("[TB] FAIL settle_set: got err=%b, want 1", settle_err);
        end else checks_passed++;
        q_ack = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks_total++;
        if (settle_err !== 1'b1 || obs !== expected_vec()) begin
            $display("[TB] FAIL settle_sticky: got err=%b vec=%h, want 1 vec=%h", settle_err, obs, expected_vec());
        end else checks_passed++;
        rst = 1'b0;
        model_reset();
        #1;
        checks_total++;
        if (settle_err !== 1'b0) begin
            $display("[TB] FAIL settle_clear: got err=%b, want 0", settle_err);
        end else checks_passed++;
        rst = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            q_ack = 8'hFF; q_data = 8'(8'h40 + i);
            tick();
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks_total++;
        if ({count, out_valid, ack_out} !== {3'd0, 1'b0, 1'b0}) begin
            $display("[TB] FAIL reset_mid: got count=%0d valid=%b ack=%b, want 0 0 0", count, out_valid, ack_out);
        end else checks_passed++;
        @(negedge clk);
        rst = 1'b1; q_ack = 8'hFF; q_data = 8'h77;
        tick();
        q_data = 8'h88;
        tick();
        q_ack = 8'h00;
        checks_total++;
        if ({out_valid, out_data, count} !== {1'b1, 8'h77, 3'd2}) begin
            $display("[TB] FAIL reset_mid_first: got valid=%b data=%h count=%0d, want 1 77 2", out_valid, out_data, count);
        end else checks_passed++;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            q_ack     = (r < 6) ? 8'hFF : (r < 8) ? 8'h00 : 8'($urandom);
            q_data    = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks_total++;
            if (ack_out !== model_push()) begin
                $display("[TB] FAIL random_ack cyc%0d: got %b, want %b", i, ack_out, model_push());
            end else checks_passed++;
            tick();
            checks_total++;
            if (obs !== expected_vec()) begin
                $display("[TB] FAIL random_state cyc%0d: got %h, want %h", i, obs, expected_vec());
            end else checks_passed++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_full_push_pop();
        test_wrap();
        test_settle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/q_capture_fifo.md
# q_capture_fifo

Downstream stage for a bank of Q-flops: each rising `clk` on which every Q-flop acknowledges, it samples the bank's outputs into a small first-word-fall-through FIFO. The FIFO is drained by a synchronous valid/ready consumer. It produces the aggregated acknowledge that drives the Q-clock, withholding it when no space is available so the Q-clock stalls instead of losing data. It also flags Q-flops that fail to settle within a bounded time.

## Interface
Parameters:
- `WIDTH`, default 8: number of Q-flops in the bank (data bits per word).
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `TIMEOUT`, default 15: consecutive cycles of partial acknowledge before `settle_err` sets; ≥ 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  Q-clock domain clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; 0 forces reset immediately.
- `q_data`  in  WIDTH  Q-flop `out` bits.
- `q_ack`  in  WIDTH  Q-flop `ack` bits, one per flop.
- `ack_out`  out  1  aggregated acknowledge to the Q-clock.
- `out_data`  out  WIDTH  head-of-FIFO word.
- `out_valid`  out  1  head word present.
- `out_ready`  in  1  consumer accepts head word.
- `count`  out  $clog2(DEPTH)+1  entries held.
- `full`  out  1  count == DEPTH.
- `settle_err`  out  1  sticky settle-timeout flag.

## Operation
- `all_ack = &q_ack`.
- `pop = out_valid & out_ready`.
- `push = all_ack & (~full | out_ready)`: a push into a full FIFO is legal only when a pop occurs in the same cycle.
- `ack_out = push`. It is combinational from `q_ack`, `full` and `out_ready`, and is forced to 0 while `rst` is 0.
- Push: write `q_data` at the write pointer, then advance the pointer. Pointers are `$clog2(DEPTH)` bits and wrap naturally from DEPTH-1 to 0.
- Pop: advance the read pointer.
- `count` update: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Push and pop may coincide at any fill level:
  - When empty, a pop is impossible because `out_valid` is 0.
  - When full, push+pop keeps `count` = DEPTH.
- `out_data = mem[rd_ptr]`. It reflects the head entry whenever `out_valid` is 1.
- `out_valid = (count != 0)`. `full = (count == DEPTH)`.
- Settle monitor:
  - Partial ack is `q_ack` neither all-zeros nor all-ones.
  - `stall_cnt` increments on each cycle with partial ack and saturates at TIMEOUT.
  - `stall_cnt` clears on any cycle without partial ack.
  - `settle_err` sets when `stall_cnt` reaches TIMEOUT and stays set until reset.
- Backpressure stall: a full FIFO with `out_ready` = 0 and `all_ack` = 1 is not a partial ack. It does not advance `stall_cnt`.
- Reset mid-operation:
  - Pointers, `count` and the stall counter clear immediately.
  - FIFO storage clears to 0.
  - Any in-flight words are discarded.

## Timing
- Reset values: `ack_out` = 0, `out_data` = 0, `out_valid` = 0, `count` = 0, `full` = 0, `settle_err` = 0.
- Latency: a word pushed at edge N appears on `out_data` with `out_valid` = 1 after edge N when the FIFO was empty. A word pushed behind others appears once it reaches the head.
- Ordering is strict FIFO; no word is duplicated or dropped.
- `ack_out` follows `q_ack` and `out_ready` in the same cycle with no register stage. The Q-clock samples it to launch its next edge.
- `settle_err` rises on the edge that ends the TIMEOUT-th consecutive partial-ack cycle.
- Deassertion of `rst` takes effect at the next rising `clk`. The first push is possible on that edge.

## Test plan
- Reset then single word: hold `rst` = 0, check all outputs at reset values. Release `rst`, drive `q_ack` = 8'hFF, `q_data` = 8'hA5 for one edge, `out_ready` = 0 → `out_valid` = 1, `out_data` = 8'hA5, `count` = 1.
- Fill and stall: push 8'h01…8'h04 with `out_ready` = 0 → `full` = 1, `count` = 4. With `q_ack` = 8'hFF held, `ack_out` = 0 and `settle_err` stays 0. Raise `out_ready` for 4 edges → reads 01,02,03,04 in order, then `out_valid` = 0.
- Full push+pop: with the FIFO full of 10..13, hold `out_ready` = 1, `q_ack` = 8'hFF, `q_data` = 8'h20 for one edge → `ack_out` = 1, `count` stays 4, head becomes 8'h11, tail holds 8'h20.
- Wrap-around: stream 12 words 0..11 with `out_ready` = 1 throughout → all 12 are received in order and `count` never exceeds 1.
- Settle timeout: drive `q_ack` = 8'h0F for 14 edges → `settle_err` = 0, and no push occurs. Drive it for 1 more edge → `settle_err` = 1. Drive `q_ack` = 8'hFF → `settle_err` remains 1 until `rst` = 0.
- Reset mid-stream: with `count` = 3, assert `rst` = 0 asynchronously between edges → `count` = 0, `out_valid` = 0, `ack_out` = 0 immediately. After release, the next word pushed is the first one read.
